hdmi_line_fetch_ctrl: RTL and testbench

- Schedules frame-buffer reads from external memory (Avalon-MM burst master) into the HDMI output pixel FIFO, one 1280-pixel line at a time, paced by the video timing generator.
- Selects which of two frame buffers is scanned out, switching only at frame start, so the camera/HDR writer never tears the displayed image.
- Sits between the memory interconnect and the pixel FIFO that feeds the 720p timing/output stage.

---
 rtl/hdmi_pkg.sv | 28 ++
 rtl/hdmi_line_fetch_ctrl_if.sv | 22 ++
 rtl/hdmi_buf_select.sv | 45 ++++
 rtl/hdmi_line_fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hdmi_line_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pkg.sv
// Shared 720p video constants, frame-buffer fetch geometry and the line-fetch FSM state type.
package hdmi_pkg;

    // 1280x720p60 timing, in pixels/lines
    localparam int H_ACTIVE = 1280;
    localparam int H_FRONT  = 110;
    localparam int H_SYNC   = 40;
    localparam int H_BACK   = 220;
    localparam int V_ACTIVE = 720;
    localparam int V_FRONT  = 5;
    localparam int V_SYNC   = 5;
    localparam int V_BACK   = 20;

    localparam int H_WORDS        = H_ACTIVE;
    localparam int V_LINES        = V_ACTIVE;
    localparam int BURST_LEN      = 64;
    localparam int BYTES_PER_WORD = 4;
    localparam int FIFO_DEPTH     = 2048;
    localparam int BURSTCOUNT_W   = 7;
    localparam int FIFO_USED_W    = 12;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ISSUE
    } fetch_state_e;

endpackage

// File: rtl/hdmi_line_fetch_ctrl_if.sv
// Avalon-MM burst read channel between the line fetcher and the memory interconnect.
interface hdmi_line_fetch_ctrl_if
    import hdmi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   avm_address_o;
    logic                    avm_read_o;
    logic [BURSTCOUNT_W-1:0] avm_burstcount_o;
    logic                    avm_waitrequest_i;
    logic                    avm_readdatavalid_i;

    modport master (
        output avm_address_o, avm_read_o, avm_burstcount_o,
        input  avm_waitrequest_i, avm_readdatavalid_i
    );

    modport slave (
        input  avm_address_o, avm_read_o, avm_burstcount_o,
        output avm_waitrequest_i, avm_readdatavalid_i
    );
endinterface

// File: rtl/hdmi_buf_select.sv
// Double-buffer selection: remembers the newest completed frame and flips scan-out only at frame start.
module hdmi_buf_select (
    input  logic clk,
    input  logic reset,
    input  logic frame_start_i,
    input  logic wr_done_i,
    input  logic wr_idx_i,
    output logic sel_idx_o,
    output logic rd_idx_o
);
    logic latest_q, latest_d;
    logic flag_q, flag_d;
    logic rd_idx_q, rd_idx_d;

    always_comb begin
        latest_d = latest_q;
        flag_d   = flag_q;
        rd_idx_d = rd_idx_q;
        if (wr_done_i) begin
            latest_d = wr_idx_i;
            flag_d   = 1'b1;
        end
        if (frame_start_i) begin
            // a completion landing on the frame-start cycle is taken immediately
            if (wr_done_i)   rd_idx_d = wr_idx_i;
            else if (flag_q) rd_idx_d = latest_q;
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latest_q <= 1'b0;
            flag_q   <= 1'b0;
            rd_idx_q <= 1'b0;
        end else begin
            latest_q <= latest_d;
            flag_q   <= flag_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign sel_idx_o = rd_idx_d;
    assign rd_idx_o  = rd_idx_q;
endmodule

// File: rtl/hdmi_line_fetch_ctrl.sv
// Line-at-a-time frame-buffer prefetcher: credit-checked Avalon bursts into the HDMI pixel FIFO.
module hdmi_line_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int H_WORDS    = hdmi_pkg::H_WORDS,
    parameter int V_LINES    = hdmi_pkg::V_LINES,
    parameter int BURST_LEN  = hdmi_pkg::BURST_LEN,
    parameter int FIFO_DEPTH = hdmi_pkg::FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start_i,
    input  logic                   line_req_i,
    input  logic [ADDR_WIDTH-1:0]  buf0_base_i,
    input  logic [ADDR_WIDTH-1:0]  buf1_base_i,
    input  logic                   wr_done_i,
    input  logic                   wr_idx_i,
    input  logic [11:0]            fifo_used_i,
    hdmi_line_fetch_ctrl_if.master avm,
    output logic                   rd_idx_o,
    output logic                   busy_o,
    output logic                   line_miss_o
);
    import hdmi_pkg::*;

    localparam int BURSTS   = H_WORDS / BURST_LEN;
    localparam int BCNT_W   = $clog2(BURSTS + 1);
    localparam int LCNT_W   = $clog2(V_LINES + 1);
    localparam int OUT_W    = 12;
    localparam int CREDIT_W = 14;
    localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_LEN * BYTES_PER_WORD);
    localparam logic [BCNT_W-1:0]     LAST_BURST = BCNT_W'(BURSTS - 1);
    localparam logic [LCNT_W-1:0]     LINE_LIMIT = LCNT_W'(V_LINES);

    fetch_state_e            state_q, state_d;
    logic                    pending_q, pending_d;
    logic                    busy_q, busy_d;
    logic                    miss_q, miss_d;
    logic                    restart_q, restart_d;
    logic [LCNT_W-1:0]       line_cnt_q, line_cnt_d;
    logic [BCNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic [OUT_W-1:0]        outstanding_q, outstanding_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;

    logic                    sel_idx;
    logic [ADDR_WIDTH-1:0]   sel_base;
    logic                    accept;
    logic [CREDIT_W-1:0]     credit;

    hdmi_buf_select u_buf_select (
        .clk           (clk),
        .reset         (reset),
        .frame_start_i (frame_start_i),
        .wr_done_i     (wr_done_i),
        .wr_idx_i      (wr_idx_i),
        .sel_idx_o     (sel_idx),
        .rd_idx_o      (rd_idx_o)
    );

    assign sel_base = sel_idx ? buf1_base_i : buf0_base_i;
    assign accept   = (state_q == ISSUE) && !avm.avm_waitrequest_i;
    assign credit   = CREDIT_W'(fifo_used_i) + CREDIT_W'(outstanding_q) + CREDIT_W'(BURST_LEN);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        busy_d        = busy_q;
        miss_d        = miss_q;
        restart_d     = restart_q;
        line_cnt_d    = line_cnt_q;
        burst_cnt_d   = burst_cnt_q;
        addr_d        = addr_q;
        base_d        = base_q;
        outstanding_d = outstanding_q + (accept ? OUT_W'(BURST_LEN) : '0)
                        - OUT_W'(avm.avm_readdatavalid_i);

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (credit <= CREDIT_W'(FIFO_DEPTH)) state_d = ISSUE;
            end
            ISSUE: begin
                if (accept) begin
                    if (restart_q) begin
                        // burst was held across a frame start; resume from the new frame base
                        addr_d    = base_q;
                        restart_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        addr_d = addr_q + BURST_STEP;
                        if (burst_cnt_q == LAST_BURST) begin
                            line_cnt_d  = line_cnt_q + 1'b1;
                            burst_cnt_d = '0;
                            busy_d      = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            burst_cnt_d = burst_cnt_q + 1'b1;
                            state_d     = CHECK;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (line_req_i && (line_cnt_q < LINE_LIMIT)) begin
            if (pending_q || busy_q) miss_d = 1'b1;
            pending_d = 1'b1;
        end

        if (frame_start_i) begin
            pending_d   = 1'b1;
            line_cnt_d  = '0;
            burst_cnt_d = '0;
            base_d      = sel_base;
            if ((state_q == ISSUE) && !accept) begin
                restart_d = 1'b1;
            end else begin
                addr_d    = sel_base;
                restart_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            miss_q        <= 1'b0;
            restart_q     <= 1'b0;
            line_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            outstanding_q <= '0;
            addr_q        <= '0;
            base_q        <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            miss_q        <= miss_d;
            restart_q     <= restart_d;
            line_cnt_q    <= line_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            outstanding_q <= outstanding_d;
            addr_q        <= addr_d;
            base_q        <= base_d;
        end
    end

    assign avm.avm_read_o       = (state_q == ISSUE);
    assign avm.avm_address_o    = addr_q;
    assign avm.avm_burstcount_o = BURSTCOUNT_W'(BURST_LEN);
    assign busy_o               = busy_q;
    assign line_miss_o          = miss_q;
endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Directed bench for hdmi_line_fetch_ctrl with a burst-address scoreboard and an Avalon read slave model.
module tb_hdmi_line_fetch_ctrl;
  localparam int H = 1280, BL = 64, VL = 8, BPL = H / BL;
  localparam int LINE_BYTES = H * 4, BURST_BYTES = BL * 4;

  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, line_req = 1'b0;
  logic wr_done = 1'b0, wr_idx = 1'b0;
  logic [11:0] fifo_used = 12'd0;
  logic [31:0] buf0 = 32'h1000_0000, buf1 = 32'h2000_0000;
  logic rd_idx, busy, miss;
  int n_cmp = 0, n_err = 0, owed = 0;
  logic [31:0] exp_q[$];

  hdmi_line_fetch_ctrl_if #(.ADDR_WIDTH(32)) avm ();

  hdmi_line_fetch_ctrl #(.ADDR_WIDTH(32), .V_LINES(VL)) dut (
    .clk(clk), .reset(reset), .frame_start_i(frame_start), .line_req_i(line_req),
    .buf0_base_i(buf0), .buf1_base_i(buf1), .wr_done_i(wr_done), .wr_idx_i(wr_idx),
    .fifo_used_i(fifo_used), .avm(avm), .rd_idx_o(rd_idx), .busy_o(busy), .line_miss_o(miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // slave: one word back per cycle for every accepted burst; bursts checked against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      owed = 0;
      avm.avm_readdatavalid_i = 1'b0;
    end else begin
      avm.avm_readdatavalid_i = (owed > 0);
      if (owed > 0) owed--;
      if (avm.avm_read_o && !avm.avm_waitrequest_i) begin
        owed += BL;
        chk("burst_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("burst_addr", avm.avm_address_o, exp_q.pop_front());
        chk("burstcount", 32'(avm.avm_burstcount_o), 32'(BL));
      end
    end
  end

  task automatic push_line(input logic [31:0] base, input int line);
    for (int i = 0; i < BPL; i++) exp_q.push_back(base + 32'(line * LINE_BYTES + i * BURST_BYTES));
  endtask

  task automatic pulse_line_req();
    @(posedge clk); #1 line_req = 1'b1;
    @(posedge clk); #1 line_req = 1'b0;
  endtask

  task automatic pulse_frame_start();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < 3000) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_read(input string tag);
    int n = 0;
    @(negedge clk);
    while (!avm.avm_read_o && n < 200) begin @(negedge clk); n++; end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (dut.outstanding_q != 12'd0 && n < 4000) begin @(negedge clk); n++; end
    chk(tag, 32'(dut.outstanding_q), 32'd0);
  endtask

  initial begin
    logic [31:0] hd;
    avm.avm_waitrequest_i = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", 32'(avm.avm_read_o), 32'd0);
    chk("rst_addr", avm.avm_address_o, 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // first frame: line 0 of buf0, read two cycles after pending
    push_line(buf0, 0);
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk); chk("lat_pending", 32'(avm.avm_read_o), 32'd0);
    @(negedge clk); chk("lat_check_rd", 32'(avm.avm_read_o), 32'd0);
    chk("lat_check_busy", 32'(busy), 32'd1);
    @(negedge clk); chk("lat_issue", 32'(avm.avm_read_o), 32'd1);
    wait_idle("line0_done");
    chk("line0_busy", 32'(busy), 32'd0);
    wait_drain("drain0");

    // credit boundary: 2000 and 1985 hold, 1984 issues
    fifo_used = 12'd2000;
    push_line(buf0, 1);
    pulse_line_req();
    repeat (5) @(negedge clk);
    chk("credit_hold_rd", 32'(avm.avm_read_o), 32'd0);
    chk("credit_hold_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 fifo_used = 12'd1985;
    @(posedge clk); #1 fifo_used = 12'd1984;
    @(negedge clk); chk("credit_1985", 32'(avm.avm_read_o), 32'd0);
    @(negedge clk); chk("credit_1984", 32'(avm.avm_read_o), 32'd1);
    @(posedge clk); #1 fifo_used = 12'd0;
    wait_idle("line1_done");

    // waitrequest stall: request and address held until accepted
    avm.avm_waitrequest_i = 1'b1;
    push_line(buf0, 2);
    pulse_line_req();
    wait_read("stall_read");
    hd = avm.avm_address_o;
    chk("stall_first_addr", hd, buf0 + 32'(2 * LINE_BYTES));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_read_held", 32'(avm.avm_read_o), 32'd1);
      chk("stall_addr_held", avm.avm_address_o, hd);
    end
    @(posedge clk); #1 avm.avm_waitrequest_i = 1'b0;
    wait_idle("line2_done");

    // line 3 with writer completion and two extra requests mid-fetch
    push_line(buf0, 3);
    pulse_line_req();
    wait_read("line3_read");
    @(posedge clk); #1 wr_done = 1'b1; wr_idx = 1'b1;
    @(posedge clk); #1 wr_done = 1'b0; wr_idx = 1'b0;
    @(negedge clk); chk("rd_idx_midframe", 32'(rd_idx), 32'd0);
    push_line(buf0, 4);
    pulse_line_req();
    pulse_line_req();
    @(negedge clk); chk("miss_set", 32'(miss), 32'd1);
    wait_idle("line4_done");
    repeat (10) @(negedge clk);
    chk("line_cnt_5", 32'(dut.line_cnt_q), 32'd5);
    chk("rd_idx_before_fs", 32'(rd_idx), 32'd0);

    // next frame switches to buf1
    push_line(buf1, 0);
    pulse_frame_start();
    @(negedge clk); chk("rd_idx_switched", 32'(rd_idx), 32'd1);
    wait_idle("buf1_line0_done");
    chk("miss_sticky", 32'(miss), 32'd1);

    // frame start while a burst is stalled: held burst completes, then restart at line 0
    avm.avm_waitrequest_i = 1'b1;
    push_line(buf1, 1);
    pulse_line_req();
    wait_read("fs_stall_read");
    chk("fs_stall_addr", avm.avm_address_o, buf1 + 32'(LINE_BYTES));
    hd = exp_q[0];
    exp_q.delete();
    exp_q.push_back(hd);
    push_line(buf1, 0);
    pulse_frame_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fs_read_held", 32'(avm.avm_read_o), 32'd1);
      chk("fs_addr_held", avm.avm_address_o, hd);
    end
    @(posedge clk); #1 avm.avm_waitrequest_i = 1'b0;
    wait_idle("fs_restart_done");
    wait_drain("fs_drain");
    chk("fs_rd_idx", 32'(rd_idx), 32'd1);

    // writer completion coinciding with frame start takes effect immediately
    push_line(buf0, 0);
    @(posedge clk); #1 frame_start = 1'b1; wr_done = 1'b1; wr_idx = 1'b0;
    @(posedge clk); #1 frame_start = 1'b0; wr_done = 1'b0;
    @(negedge clk); chk("coincide_rd_idx", 32'(rd_idx), 32'd0);
    wait_idle("coincide_done");

    // reset while a read is held
    avm.avm_waitrequest_i = 1'b1;
    pulse_line_req();
    wait_read("rst_hold_read");
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_read", 32'(avm.avm_read_o), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_miss", 32'(miss), 32'd0);
    chk("rst2_outstanding", 32'(dut.outstanding_q), 32'd0);
    @(posedge clk); #1 reset = 1'b0; avm.avm_waitrequest_i = 1'b0;

    // full (short) frame, then a request past the last line is ignored
    push_line(buf0, 0);
    pulse_frame_start();
    wait_idle("eof_line0");
    for (int l = 1; l < VL; l++) begin
      push_line(buf0, l);
      pulse_line_req();
      wait_idle("eof_line");
    end
    pulse_line_req();
    repeat (20) @(negedge clk);
    chk("eof_busy", 32'(busy), 32'd0);
    chk("eof_read", 32'(avm.avm_read_o), 32'd0);
    chk("eof_miss", 32'(miss), 32'd0);
    chk("eof_line_cnt", 32'(dut.line_cnt_q), 32'(VL));
    wait_drain("eof_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
